// File: rtl/rambus_pkg.sv
// Shared definitions for the rambus Wishbone initiators: bus widths and the burst FSM state encoding.
// Pure declarations; no latency or backpressure of its own.
package rambus_pkg;

    localparam int RAMBUS_ADDR_W = 10;
    localparam int RAMBUS_DATA_W = 32;
    localparam int RAMBUS_SEL_W  = RAMBUS_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        BUS   = 3'd2,
        RHOLD = 3'd3,
        DONE  = 3'd4
    } rambus_state_e;

endpackage

// File: rtl/rambus_ack_timer.sv
// Per-beat ack watchdog: counts cycles while enabled, flags expiry on the TIMEOUT-th counted cycle.
// Expiry is combinational from the count register; clear has priority and takes effect next cycle.
module rambus_ack_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic cnt_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Saturates at the expiry value so the flag holds until cleared.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (cnt_i && !expired_o) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expired_o = (count_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rambus_wb_initiator.sv
// Wishbone classic initiator: one command becomes cmd_len+1 single-beat cycles on the rambus port.
// Command accept -> stb next cycle; wr/rd streams stall the burst via valid/ready, ack timeout aborts.
module rambus_wb_initiator
    import rambus_pkg::*;
#(
    parameter int ADDR_WIDTH = RAMBUS_ADDR_W,
    parameter int LEN_WIDTH  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,

    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [RAMBUS_DATA_W-1:0]  wr_data,
    input  logic [RAMBUS_SEL_W-1:0]   wr_sel,

    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [RAMBUS_DATA_W-1:0]  rd_data,

    output logic                      done,
    output logic                      err,

    output logic                      rambus_wb_clk_o,
    output logic                      rambus_wb_rst_o,
    output logic                      rambus_wb_cyc_o,
    output logic                      rambus_wb_stb_o,
    output logic                      rambus_wb_we_o,
    output logic [RAMBUS_SEL_W-1:0]   rambus_wb_sel_o,
    output logic [ADDR_WIDTH-1:0]     rambus_wb_adr_o,
    output logic [RAMBUS_DATA_W-1:0]  rambus_wb_dat_o,
    input  logic                      rambus_wb_ack_i,
    input  logic [RAMBUS_DATA_W-1:0]  rambus_wb_dat_i
);

    rambus_state_e              state_q, state_d;
    logic                       init_q;
    logic                       we_q, we_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [LEN_WIDTH-1:0]       count_q, count_d;
    logic [RAMBUS_SEL_W-1:0]    sel_q, sel_d;
    logic [RAMBUS_DATA_W-1:0]   dat_q, dat_d;
    logic [RAMBUS_DATA_W-1:0]   rdat_q, rdat_d;
    logic                       err_q, err_d;

    logic                       in_bus;
    logic                       last_beat;
    logic                       tmr_expired;

    assign in_bus    = (state_q == BUS);
    assign last_beat = (count_q == '0);

    // Timer runs only while a beat is outstanding; any other cycle re-arms it.
    rambus_ack_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_ack_timer (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .clr_i     (!in_bus || rambus_wb_ack_i),
        .cnt_i     (in_bus),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        count_d = count_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && init_q) begin
                    we_d    = cmd_we;
                    addr_d  = cmd_addr & ~ADDR_WIDTH'(3);
                    count_d = cmd_len;
                    err_d   = 1'b0;
                    sel_d   = cmd_we ? sel_q : '1;
                    state_d = cmd_we ? WDATA : BUS;
                end
            end
            WDATA: begin
                if (wr_valid) begin
                    dat_d   = wr_data;
                    sel_d   = wr_sel;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (rambus_wb_ack_i) begin
                    if (!we_q) begin
                        rdat_d  = rambus_wb_dat_i;
                        state_d = RHOLD;
                    end else if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(4);
                        count_d = count_q - LEN_WIDTH'(1);
                        state_d = WDATA;
                    end
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            RHOLD: begin
                if (rd_ready) begin
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(4);
                        count_d = count_q - LEN_WIDTH'(1);
                        state_d = BUS;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holds cmd_ready low through reset and for the first edge after release.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sel_q  <= '0;
            dat_q  <= '0;
            rdat_q <= '0;
        end else begin
            sel_q  <= sel_d;
            dat_q  <= dat_d;
            rdat_q <= rdat_d;
        end
    end

    // Bus strobes decode straight from state so reset removes them without waiting for a clock.
    assign cmd_ready       = (state_q == IDLE) && init_q;
    assign wr_ready        = (state_q == WDATA);
    assign rd_valid        = (state_q == RHOLD);
    assign rd_data         = rdat_q;
    assign done            = (state_q == DONE);
    assign err             = err_q;

    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = ~wb_rst_ni;
    assign rambus_wb_cyc_o = (state_q == WDATA) || in_bus || (state_q == RHOLD);
    assign rambus_wb_stb_o = in_bus;
    assign rambus_wb_we_o  = we_q && in_bus;
    assign rambus_wb_sel_o = sel_q;
    assign rambus_wb_adr_o = addr_q;
    assign rambus_wb_dat_o = dat_q;

endmodule

// File: tb/tb_rambus_wb_initiator.sv
// Directed bench for rambus_wb_initiator with a one-wait-state memory slave model.
module tb_rambus_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [9:0]  cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_sel = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic        wb_clk_o;
    logic        wb_rst_o;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [9:0]  adr;
    logic [31:0] dat_o;
    logic        ack = 1'b0;
    logic [31:0] dat_i = '0;

    rambus_wb_initiator #(
        .ADDR_WIDTH (10),
        .LEN_WIDTH  (8),
        .TIMEOUT    (64)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_we          (cmd_we),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_data         (wr_data),
        .wr_sel          (wr_sel),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_data         (rd_data),
        .done            (done),
        .err             (err),
        .rambus_wb_clk_o (wb_clk_o),
        .rambus_wb_rst_o (wb_rst_o),
        .rambus_wb_cyc_o (cyc),
        .rambus_wb_stb_o (stb),
        .rambus_wb_we_o  (we),
        .rambus_wb_sel_o (sel),
        .rambus_wb_adr_o (adr),
        .rambus_wb_dat_o (dat_o),
        .rambus_wb_ack_i (ack),
        .rambus_wb_dat_i (dat_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Slave: memory word i holds A500_00ii until written; acks one cycle after stb.
    logic        slv_en = 1'b1;
    logic [31:0] mem [256];
    logic [9:0]  beat_adr [$];
    logic [31:0] beat_dat [$];
    logic [3:0]  beat_sel [$];
    logic        beat_we  [$];
    logic [31:0] rd_q [$];
    int          done_cnt = 0;
    int          proto_err = 0;

    initial for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (cyc && stb && !ack && slv_en) begin
                ack <= 1'b1;
                beat_adr.push_back(adr);
                beat_dat.push_back(dat_o);
                beat_sel.push_back(sel);
                beat_we.push_back(we);
                if (we) mem[adr[9:2]] <= dat_o;
                else    dat_i <= mem[adr[9:2]];
            end
        end
    end

    always @(posedge clk) begin
        if (stb && !cyc) proto_err <= proto_err + 1;
        if (rd_valid && rd_ready) rd_q.push_back(rd_data);
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired CHECKS %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        beat_adr.delete();
        beat_dat.delete();
        beat_sel.delete();
        beat_we.delete();
        rd_q.delete();
    endtask

    task automatic do_cmd(input logic w, input logic [9:0] a, input logic [7:0] l);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_addr  = a;
        cmd_len   = l;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_in_time", 32'(n < 200), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_sel   = s;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_ready && n < 200);
        check("wr_accept_in_time", 32'(n < 200), 1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 400);
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_cyc_low_in_done"}, cyc, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    typedef struct {
        logic [9:0]  addr;
        logic [7:0]  len;
        int          exp_beats;
        logic [9:0]  exp_first_adr;
        logic [9:0]  exp_last_adr;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } rvec_t;

    task automatic test_read_table();
        rvec_t tbl [4];
        tbl[0] = '{10'h010, 8'd0, 1, 10'h010, 10'h010, 32'hA500_0004, 32'hA500_0004};
        tbl[1] = '{10'h013, 8'd1, 2, 10'h010, 10'h014, 32'hA500_0004, 32'hA500_0005};
        tbl[2] = '{10'h3FC, 8'd1, 2, 10'h3FC, 10'h000, 32'hA500_00FF, 32'hA500_0000};
        tbl[3] = '{10'h100, 8'd3, 4, 10'h100, 10'h10C, 32'hA500_0040, 32'hA500_0043};
        rd_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            string tag;
            int    dc;
            tag = $sformatf("rd%0d", v);
            clear_logs();
            dc = done_cnt;
            do_cmd(1'b0, tbl[v].addr, tbl[v].len);
            wait_done(tag, 1'b0);
            check({tag, "_beats"}, beat_adr.size(), tbl[v].exp_beats);
            check({tag, "_words"}, rd_q.size(), tbl[v].exp_beats);
            check({tag, "_first_adr"}, beat_adr.size() > 0 ? 32'(beat_adr[0]) : 32'hx, 32'(tbl[v].exp_first_adr));
            check({tag, "_last_adr"}, beat_adr.size() > 0 ? 32'(beat_adr[$]) : 32'hx, 32'(tbl[v].exp_last_adr));
            check({tag, "_sel"}, beat_sel.size() > 0 ? 32'(beat_sel[0]) : 32'hx, 32'hF);
            check({tag, "_first_word"}, rd_q.size() > 0 ? rd_q[0] : 32'hx, tbl[v].exp_first);
            check({tag, "_last_word"}, rd_q.size() > 0 ? rd_q[$] : 32'hx, tbl[v].exp_last);
            check({tag, "_one_done"}, done_cnt - dc, 1);
        end
    endtask

    task automatic test_latency();
        clear_logs();
        rd_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 10'h010;
        cmd_len   = 8'd0;
        check("t1_ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("t1_stb_next_cycle", stb, 1);
        check("t1_cyc", cyc, 1);
        check("t1_we_low", we, 0);
        check("t1_adr", adr, 10'h010);
        check("t1_sel", sel, 4'hF);
        wait_done("t1", 1'b0);
        check("t1_word", rd_q.size() > 0 ? rd_q[0] : 32'hx, 32'hA500_0004);
    endtask

    task automatic test_write_wrap();
        logic [9:0]  ea [3];
        logic [31:0] ed [3];
        logic [3:0]  es [3];
        int          dc;
        ea[0] = 10'h3F8; ed[0] = 32'hDEAD_0001; es[0] = 4'hF;
        ea[1] = 10'h3FC; ed[1] = 32'hDEAD_0002; es[1] = 4'h3;
        ea[2] = 10'h000; ed[2] = 32'hDEAD_0003; es[2] = 4'hC;
        clear_logs();
        dc = done_cnt;
        do_cmd(1'b1, 10'h3F8, 8'd2);
        for (int i = 0; i < 3; i++) feed(ed[i], es[i]);
        wait_done("t2", 1'b0);
        check("t2_beats", beat_adr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < beat_adr.size()) begin
                check($sformatf("t2_adr%0d", i), beat_adr[i], ea[i]);
                check($sformatf("t2_dat%0d", i), beat_dat[i], ed[i]);
                check($sformatf("t2_sel%0d", i), beat_sel[i], es[i]);
                check($sformatf("t2_we%0d", i), beat_we[i], 1);
            end
        end
        check("t2_one_done", done_cnt - dc, 1);
    endtask

    task automatic test_read_hold();
        clear_logs();
        rd_ready = 1'b0;
        do_cmd(1'b0, 10'h200, 8'd3);
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rd_valid && n < 200);
            check($sformatf("t3_word%0d", k), rd_data, 32'hA500_0080 + 32'(k));
            if (k == 1) begin
                logic [31:0] held;
                bit          stable = 1'b1;
                bit          stb_low = 1'b1;
                held = rd_data;
                repeat (5) begin
                    @(negedge clk);
                    if (rd_data !== held || !rd_valid) stable = 1'b0;
                    if (stb) stb_low = 1'b0;
                end
                check("t3_hold_stable", 32'(stable), 1);
                check("t3_stb_low_in_hold", 32'(stb_low), 1);
            end
            rd_ready = 1'b1;
            @(posedge clk);
            #1 rd_ready = 1'b0;
        end
        wait_done("t3", 1'b0);
        check("t3_beats", beat_adr.size(), 4);
    endtask

    task automatic test_timeout();
        int c = 0;
        slv_en = 1'b0;
        do_cmd(1'b1, 10'h040, 8'd0);
        feed(32'hBAD0_0001, 4'hF);
        @(negedge clk);
        while (stb && c < 200) begin
            c++;
            @(negedge clk);
        end
        check("t4_stb_cycles", c, 64);
        check("t4_cyc_low", cyc, 0);
        check("t4_done", done, 1);
        check("t4_err", err, 1);
        slv_en = 1'b1;
        rd_ready = 1'b1;
        do_cmd(1'b0, 10'h010, 8'd0);
        check("t4_err_cleared_on_accept", err, 0);
        wait_done("t4_next", 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        int dc;
        bit seen_done = 1'b0;
        slv_en = 1'b0;
        do_cmd(1'b0, 10'h100, 8'd3);
        @(negedge clk);
        check("t5_stb_before_reset", stb, 1);
        dc = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("t5_cyc_async_low", cyc, 0);
        check("t5_stb_async_low", stb, 0);
        check("t5_rst_o_high", wb_rst_o, 1);
        repeat (2) @(negedge clk);
        slv_en = 1'b1;
        rst_n  = 1'b1;
        #1;
        check("t5_ready_low_at_release", cmd_ready, 0);
        @(negedge clk);
        check("t5_ready_after_release", cmd_ready, 1);
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("t5_no_done", done_cnt - dc + int'(seen_done), 0);
    endtask

    task automatic test_held_valid();
        int t = 0;
        int t_done = -1;
        int t_acc2 = -1;
        int acc = 0;
        bit overlap = 1'b0;
        @(posedge clk);
        #1;
        rd_ready  = 1'b1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 10'h020;
        cmd_len   = 8'd0;
        while (acc < 2 && t < 100) begin
            @(negedge clk);
            t++;
            if (done) begin
                t_done = t;
                if (cmd_ready) overlap = 1'b1;
            end
            if (cmd_valid && cmd_ready) begin
                acc++;
                if (acc == 2) t_acc2 = t;
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("t6_second_accept_after_done", t_acc2, t_done + 1);
        check("t6_no_ready_in_done", 32'(overlap), 0);
        wait_done("t6", 1'b0);
    endtask

    initial begin
        #12;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_cyc", cyc, 0);
        check("rst_stb", stb, 0);
        check("rst_we", we, 0);
        check("rst_sel", sel, 0);
        check("rst_adr", adr, 0);
        check("rst_dat", dat_o, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rst_o", wb_rst_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready_still_low", cmd_ready, 0);
        @(negedge clk);
        check("rel_ready_high", cmd_ready, 1);
        check("rel_rst_o_low", wb_rst_o, 0);
        check("clk_passthrough", wb_clk_o, clk);

        test_latency();
        test_read_table();
        test_write_wrap();
        test_read_hold();
        test_timeout();
        test_reset_mid_burst();
        test_held_valid();

        check("stb_without_cyc", proto_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
